// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: IMM_W-bit immediate to DATA_W bits (sign, zero, branch, upper)
// with a registered valid/ready output. Prefix beats are enabled by defining IMMX_PREFIX_EN.
module imm_extend_pipe #(
  parameter int IMM_W  = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [1:0]        in_mode,
  input  logic              in_pfx,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic              pfx_pending
);

  localparam int PFX_W = DATA_W - IMM_W;

  function automatic logic [DATA_W-1:0] sign_ext(input logic [IMM_W-1:0] imm);
    return {{PFX_W{imm[IMM_W-1]}}, imm};
  endfunction

  function automatic logic [DATA_W-1:0] zero_ext(input logic [IMM_W-1:0] imm);
    return {{PFX_W{1'b0}}, imm};
  endfunction

  // Branch offsets are halfword-scaled; the top sign bit falls off the end.
  function automatic logic [DATA_W-1:0] branch_ext(input logic [IMM_W-1:0] imm);
    logic [DATA_W-1:0] s;
    s = sign_ext(imm);
    return {s[DATA_W-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_W-1:0] upper_ext(input logic [IMM_W-1:0] imm);
    return {imm, {PFX_W{1'b0}}};
  endfunction

  logic              accept;
  logic              is_pfx;
  logic              beat_norm;
  logic [DATA_W-1:0] base_data;
  logic [DATA_W-1:0] next_data;

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign beat_norm = accept && !is_pfx;

  // Extension of the incoming immediate, ignoring any prefix.
  always_comb begin
    base_data = {DATA_W{1'b0}};
    case (in_mode)
      2'b00:   base_data = sign_ext(in_imm);
      2'b01:   base_data = zero_ext(in_imm);
      2'b10:   base_data = branch_ext(in_imm);
      2'b11:   base_data = upper_ext(in_imm);
      default: base_data = sign_ext(in_imm);
    endcase
  end

`ifdef IMMX_PREFIX_EN
  logic [PFX_W-1:0] pfx_reg;
  logic [PFX_W-1:0] pfx_in;
  logic             pfx_held;
  logic             use_pfx;
  logic             next_err;
  logic             err_reg;

  assign is_pfx      = in_pfx;
  assign pfx_pending = pfx_held;
  assign out_err     = err_reg;
  // A flush arriving with a normal beat strips the prefix from that beat.
  assign use_pfx     = pfx_held && !flush;

  if (PFX_W <= IMM_W) begin : g_pfx_slice
    assign pfx_in = in_imm[PFX_W-1:0];
  end else begin : g_pfx_pad
    assign pfx_in = {{(PFX_W-IMM_W){1'b0}}, in_imm};
  end

  // Merge a pending prefix into sign/zero beats; branch/upper beats drop it and flag an error.
  always_comb begin
    next_data = base_data;
    next_err  = 1'b0;
    if (use_pfx) begin
      if (!in_mode[1]) begin
        next_data = {pfx_reg, in_imm};
      end else begin
        next_err = 1'b1;
      end
    end else begin
      next_err = 1'b0;
    end
  end

  // Prefix holding register; flush beats a simultaneous prefix.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pfx_reg  <= {PFX_W{1'b0}};
      pfx_held <= 1'b0;
    end else if (flush) begin
      pfx_held <= 1'b0;
    end else if (accept && is_pfx) begin
      pfx_reg  <= pfx_in;
      pfx_held <= 1'b1;
    end else if (beat_norm) begin
      pfx_held <= 1'b0;
    end
  end

  // Error flag travels with the result it describes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else if (beat_norm) begin
      err_reg <= next_err;
    end
  end
`else
  logic unused_ctrl;

  assign unused_ctrl = in_pfx ^ flush;
  assign is_pfx      = 1'b0;
  assign pfx_pending = 1'b0;
  assign out_err     = 1'b0;
  assign next_data   = base_data;
`endif

  // Output register: load on a normal beat, clear valid once consumed, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= {DATA_W{1'b0}};
    end else if (beat_norm) begin
      out_valid <= 1'b1;
      out_data  <= next_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed self-checking bench for imm_extend_pipe (default 12->16 configuration).
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_imm = 12'h000;
  logic [1:0]  in_mode = 2'b00;
  logic        in_pfx = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_err;
  logic        pfx_pending;

  int checks = 0;
  int failures = 0;
  logic [15:0] bp_exp;

  imm_extend_pipe #(.IMM_W(12), .DATA_W(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_mode(in_mode), .in_pfx(in_pfx), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err), .pfx_pending(pfx_pending)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [11:0] imm, input logic [1:0] mode,
                      input logic pfx, input logic fl);
    in_valid = 1'b1;
    in_imm   = imm;
    in_mode  = mode;
    in_pfx   = pfx;
    flush    = fl;
    step();
    in_valid = 1'b0;
    in_pfx   = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    step();
    step();
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_data", out_data, 16'h0000);
    check_eq("rst_pfx", pfx_pending, 1'b0);
    check_eq("rst_err", out_err, 1'b0);
    check_eq("rst_ready", in_ready, 1'b1);
    reset = 1'b0;
    step();

    beat(12'h800, 2'b00, 1'b0, 1'b0);
    check_eq("m00_neg_valid", out_valid, 1'b1);
    check_eq("m00_neg", out_data, 16'hF800);
    check_eq("m00_pfx", pfx_pending, 1'b0);
    step();
    check_eq("drain_valid", out_valid, 1'b0);
    beat(12'h7FF, 2'b00, 1'b0, 1'b0);
    check_eq("m00_pos", out_data, 16'h07FF);
    beat(12'h800, 2'b01, 1'b0, 1'b0);
    check_eq("m01", out_data, 16'h0800);
    beat(12'hFFF, 2'b10, 1'b0, 1'b0);
    check_eq("m10_neg", out_data, 16'hFFFE);
    beat(12'h400, 2'b10, 1'b0, 1'b0);
    check_eq("m10_pos", out_data, 16'h0800);
    beat(12'hABC, 2'b11, 1'b0, 1'b0);
    check_eq("m11", out_data, 16'hABC0);
    check_eq("m11_valid", out_valid, 1'b1);

`ifdef IMMX_PREFIX_EN
    beat(12'h00A, 2'b11, 1'b1, 1'b0);
    check_eq("pfx_no_out", out_valid, 1'b0);
    check_eq("pfx_set", pfx_pending, 1'b1);
    beat(12'h123, 2'b00, 1'b0, 1'b0);
    check_eq("pfx_merge", out_data, 16'hA123);
    check_eq("pfx_merge_err", out_err, 1'b0);
    check_eq("pfx_clear", pfx_pending, 1'b0);
    beat(12'h005, 2'b00, 1'b1, 1'b0);
    beat(12'h001, 2'b10, 1'b0, 1'b0);
    check_eq("pfx_drop", out_data, 16'h0002);
    check_eq("pfx_drop_err", out_err, 1'b1);
    beat(12'h00F, 2'b00, 1'b1, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check_eq("flush_clr", pfx_pending, 1'b0);
    beat(12'h010, 2'b01, 1'b0, 1'b0);
    check_eq("flush_beat", out_data, 16'h0010);
    check_eq("flush_beat_err", out_err, 1'b0);
    beat(12'h00F, 2'b00, 1'b1, 1'b1);
    check_eq("pfx_flush_same", pfx_pending, 1'b0);
    check_eq("pfx_flush_nout", out_valid, 1'b0);
    beat(12'h001, 2'b00, 1'b1, 1'b0);
    bp_exp = 16'h1234;
`else
    beat(12'h00A, 2'b00, 1'b1, 1'b0);
    check_eq("npfx_valid", out_valid, 1'b1);
    check_eq("npfx_data", out_data, 16'h000A);
    check_eq("npfx_pend", pfx_pending, 1'b0);
    beat(12'h123, 2'b00, 1'b0, 1'b1);
    check_eq("nflush_data", out_data, 16'h0123);
    beat(12'h001, 2'b10, 1'b1, 1'b0);
    check_eq("npfx_m10", out_data, 16'h0002);
    check_eq("npfx_err", out_err, 1'b0);
    step();
    bp_exp = 16'h2340;
`endif

    // Backpressure: hold a result for three cycles, then take it with a new beat waiting.
    out_ready = 1'b0;
`ifdef IMMX_PREFIX_EN
    beat(12'h234, 2'b00, 1'b0, 1'b0);
`else
    beat(12'h234, 2'b11, 1'b0, 1'b0);
`endif
    check_eq("bp_load", out_data, bp_exp);
    in_valid = 1'b1;
    in_imm   = 12'h7FF;
    in_mode  = 2'b00;
    for (int i = 0; i < 3; i++) begin
      check_eq("bp_in_ready", in_ready, 1'b0);
      step();
      check_eq("bp_hold_data", out_data, bp_exp);
      check_eq("bp_hold_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", in_ready, 1'b1);
    step();
    check_eq("bp_next_valid", out_valid, 1'b1);
    check_eq("bp_next_data", out_data, 16'h07FF);
    in_valid = 1'b0;
    step();
    check_eq("bp_drain", out_valid, 1'b0);

    // Asynchronous reset in the middle of a clock period.
    out_ready = 1'b0;
    beat(12'h555, 2'b01, 1'b0, 1'b0);
    check_eq("pre_rst_valid", out_valid, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_valid", out_valid, 1'b0);
    check_eq("arst_data", out_data, 16'h0000);
    #1 reset = 1'b0;
    out_ready = 1'b1;
`ifdef IMMX_PREFIX_EN
    beat(12'h003, 2'b00, 1'b1, 1'b0);
    check_eq("pre_rst_pfx", pfx_pending, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_pfx", pfx_pending, 1'b0);
    #1 reset = 1'b0;
`endif
    beat(12'h001, 2'b00, 1'b0, 1'b0);
    check_eq("post_rst_data", out_data, 16'h0001);
    check_eq("post_rst_valid", out_valid, 1'b1);
    check_eq("post_rst_err", out_err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
